// File: rtl/lcg_pkg.sv
// lcg_pkg: shared constants and step/temper helpers for the lcg_multi PRNG.
// Helpers work on a 64-bit container; callers keep the low WIDTH bits, which
// equal the result modulo 2^WIDTH for any WIDTH <= 64.
// Optional output tempering is selected by the LCG_TEMPER_EN macro (see lcg_channel).
package lcg_pkg;

  localparam int unsigned LCG_MAX_W         = 64;
  localparam logic [63:0] LCG_MULT_DEF      = 64'h0000_0000_3E8A_91CD;
  localparam logic [63:0] LCG_INC_BASE_DEF  = 64'h0000_0000_D472_1B61;
  localparam logic [63:0] LCG_RESET_SEED_DEF = 64'h0000_0000_0000_0001;

  // One LCG step; only the low bits of the product/sum are meaningful.
  function automatic logic [63:0] lcg_next(input logic [63:0] state,
                                           input logic [63:0] mult,
                                           input logic [63:0] inc);
    return (state * mult) + inc;
  endfunction

  // Output tempering: fold the upper half of the state into the lower half.
  function automatic logic [63:0] lcg_temper(input logic [63:0] state,
                                             input int unsigned width);
    return state ^ (state >> (width / 32'd2));
  endfunction

endpackage

// File: rtl/lcg_channel.sv
// lcg_channel: one WIDTH-bit LCG lane (state register, step, reseed).
// Ports:
//   clk     in   clock
//   rst     in   async active-low reset, state returns to RESET_VAL+IDX
//   load_i  in   reseed: state <= seed_i + IDX (has priority over step_i)
//   seed_i  in   reseed value
//   step_i  in   advance state by one LCG step
//   out_o   out  f(state): raw state, or tempered when LCG_TEMPER_EN is defined
module lcg_channel
  import lcg_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned IDX       = 0,
  parameter logic [63:0] MULT      = LCG_MULT_DEF,
  parameter logic [63:0] INC       = LCG_INC_BASE_DEF,
  parameter logic [63:0] RESET_VAL = LCG_RESET_SEED_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] out_o
);

  localparam logic [63:0]      RST_FULL = RESET_VAL + 64'(IDX);
  localparam logic [WIDTH-1:0] RST_W    = RST_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] state_q, state_d;
  logic [63:0]      next_full_s, seed_full_s, out_full_s;
  logic             unused_s;

  // Wide intermediates: only the low WIDTH bits are kept (mod 2^WIDTH).
  always_comb begin
    next_full_s = lcg_next(64'(state_q), MULT, INC);
    seed_full_s = 64'(seed_i) + 64'(IDX);
`ifdef LCG_TEMPER_EN
    out_full_s  = lcg_temper(64'(state_q), WIDTH);
`else
    out_full_s  = 64'(state_q);
`endif
  end

  assign unused_s = ^{next_full_s, seed_full_s, out_full_s};
  assign out_o    = out_full_s[WIDTH-1:0];

  // Next state: reseed beats step.
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = seed_full_s[WIDTH-1:0];
    end else if (step_i) begin
      state_d = next_full_s[WIDTH-1:0];
    end else begin
      state_d = state_q;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RST_W;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/lcg_multi.sv
// lcg_multi: CHANNELS parallel LCG lanes stepping together, with reseed,
// valid/ready output handshake and a 32-bit accepted-word counter.
// Optional feature: define LCG_TEMPER_EN to emit s ^ (s >> WIDTH/2) per lane
// instead of the raw state (the state sequence itself is unchanged).
// Ports:
//   clk        in   clock (rising edge)
//   rst        in   async active-low reset
//   en         in   generation enable
//   seed_load  in   reseed pulse, highest priority; flushes any pending word
//   seed       in   reseed value, lane i gets seed+i
//   out_valid  out  out_data holds an unconsumed word
//   out_ready  in   consumer accepts when out_valid=1
//   out_data   out  lane i at [i*WIDTH +: WIDTH]
//   word_cnt   out  number of accepted words (wraps)
module lcg_multi
  import lcg_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned CHANNELS   = 4,
  parameter logic [63:0] MULT       = LCG_MULT_DEF,
  parameter logic [63:0] INC_BASE   = LCG_INC_BASE_DEF,
  parameter logic [63:0] RESET_SEED = LCG_RESET_SEED_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      seed_load,
  input  logic [WIDTH-1:0]          seed,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [31:0]               word_cnt
);

  logic                      fire_s, accept_s;
  logic [CHANNELS*WIDTH-1:0] lane_out_s;
  logic                      out_valid_q, out_valid_d;
  logic [CHANNELS*WIDTH-1:0] out_data_q, out_data_d;
  logic [31:0]               word_cnt_q, word_cnt_d;

  // A new word is produced only when the output slot is free or being freed.
  assign fire_s   = en && !seed_load && (!out_valid_q || out_ready);
  // A word flushed by reseed is not counted even if ready was high.
  assign accept_s = out_valid_q && out_ready && !seed_load;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    localparam logic [63:0] INC_I = (INC_BASE + 64'(2 * i)) | 64'd1;
    lcg_channel #(
      .WIDTH    (WIDTH),
      .IDX      (i),
      .MULT     (MULT),
      .INC      (INC_I),
      .RESET_VAL(RESET_SEED)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .load_i(seed_load),
      .seed_i(seed),
      .step_i(fire_s),
      .out_o (lane_out_s[i*WIDTH +: WIDTH])
    );
  end

  // Output slot and counter next-state.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    word_cnt_d  = word_cnt_q;
    if (seed_load) begin
      out_valid_d = 1'b0;
    end else if (fire_s) begin
      out_valid_d = 1'b1;
      out_data_d  = lane_out_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (accept_s) begin
      word_cnt_d = word_cnt_q + 32'd1;
    end else begin
      word_cnt_d = word_cnt_q;
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      word_cnt_q  <= 32'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign word_cnt  = word_cnt_q;

endmodule
